// File: rtl/onehot_gate_sequencer.sv
// Registered N-to-2^N one-hot gate decoder with break-before-make dead time.
// Every change of the selected gate first drives all gates off for exactly
// DEAD_CYCLES clocks. Only after that is the new gate asserted, so two
// switches are never on together.
module onehot_gate_sequencer #(
    parameter int SEL_W       = 3,
    parameter int DEAD_CYCLES = 16,
    parameter int ACTIVE_LOW  = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic                  sel_valid,
    input  logic [SEL_W-1:0]      sel,
    output logic [(2**SEL_W)-1:0] gate,
    output logic                  busy,
    output logic                  switched
);

    localparam int OUTS  = 2 ** SEL_W;
    localparam int CNT_W = $clog2(DEAD_CYCLES + 1);

    // The counter is loaded with DEAD_CYCLES-1 on the edge that turns the
    // gates off. That edge is the first of the DEAD_CYCLES all-off cycles.
    localparam logic [CNT_W-1:0] DEAD_LOAD = CNT_W'(DEAD_CYCLES - 1);
    localparam logic [OUTS-1:0]  POLARITY  = (ACTIVE_LOW != 0) ? '1 : '0;
    localparam logic [OUTS-1:0]  GATE_OFF  = POLARITY;

    typedef enum logic [1:0] {
        S_OFF  = 2'd0,
        S_DEAD = 2'd1,
        S_ON   = 2'd2
    } state_t;

    state_t           state;
    logic [SEL_W-1:0] active;
    logic [SEL_W-1:0] target;
    logic [CNT_W-1:0] cnt;
    logic [SEL_W-1:0] next_target;

    // Decoded gate pattern for an index, with the output polarity applied.
    function automatic logic [OUTS-1:0] drive(input logic [SEL_W-1:0] idx);
        return (OUTS'(1) << idx) ^ POLARITY;
    endfunction

    // A request in the same cycle the dead time expires wins over the stored
    // target. The outputs are already off, so no extra dead time is needed.
    assign next_target = sel_valid ? sel : target;

    // Sequencer FSM. The gate, busy and switched outputs are all registered here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_OFF;
            active   <= '0;
            target   <= '0;
            cnt      <= '0;
            gate     <= GATE_OFF;
            busy     <= 1'b0;
            switched <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments throughout, so every branch below
            // sees the pre-edge register values. The default here makes switched
            // a single-cycle pulse; branches that enter ON override it.
            switched <= 1'b0;
            case (state)
                S_OFF: begin
                    gate <= GATE_OFF;
                    busy <= 1'b0;
                    if (en && sel_valid) begin
                        target <= sel;
                        cnt    <= DEAD_LOAD;
                        busy   <= 1'b1;
                        state  <= S_DEAD;
                    end
                end

                S_DEAD: begin
                    gate <= GATE_OFF;
                    if (!en) begin
                        busy  <= 1'b0;
                        state <= S_OFF;
                    end else begin
                        if (sel_valid) begin
                            target <= sel;
                        end
                        if (cnt == '0) begin
                            active   <= next_target;
                            gate     <= drive(next_target);
                            busy     <= 1'b0;
                            switched <= 1'b1;
                            state    <= S_ON;
                        end else begin
                            cnt <= cnt - CNT_W'(1);
                        end
                    end
                end

                S_ON: begin
                    busy <= 1'b0;
                    if (!en) begin
                        gate  <= GATE_OFF;
                        state <= S_OFF;
                    end else if (sel_valid && (sel != active)) begin
                        target <= sel;
                        cnt    <= DEAD_LOAD;
                        gate   <= GATE_OFF;
                        busy   <= 1'b1;
                        state  <= S_DEAD;
                    end else begin
                        gate <= drive(active);
                    end
                end

                default: begin
                    gate  <= GATE_OFF;
                    busy  <= 1'b0;
                    state <= S_OFF;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_onehot_gate_sequencer.sv
// Directed bench for onehot_gate_sequencer. Instance A uses SEL_W=3 and
// DEAD_CYCLES=4 with active-high gates. Instance B uses SEL_W=2 and
// DEAD_CYCLES=1 with active-low gates.
module tb_onehot_gate_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Instance A
    logic       rst_n_a, en_a, sel_valid_a;
    logic [2:0] sel_a;
    logic [7:0] gate_a;
    logic       busy_a, switched_a;

    onehot_gate_sequencer #(.SEL_W(3), .DEAD_CYCLES(4), .ACTIVE_LOW(0)) dut_a (
        .clk       (clk),
        .rst_n     (rst_n_a),
        .en        (en_a),
        .sel_valid (sel_valid_a),
        .sel       (sel_a),
        .gate      (gate_a),
        .busy      (busy_a),
        .switched  (switched_a)
    );

    // Instance B
    logic       rst_n_b, en_b, sel_valid_b;
    logic [1:0] sel_b;
    logic [3:0] gate_b;
    logic       busy_b, switched_b;

    onehot_gate_sequencer #(.SEL_W(2), .DEAD_CYCLES(1), .ACTIVE_LOW(1)) dut_b (
        .clk       (clk),
        .rst_n     (rst_n_b),
        .en        (en_b),
        .sel_valid (sel_valid_b),
        .sel       (sel_b),
        .gate      (gate_b),
        .busy      (busy_b),
        .switched  (switched_b)
    );

    function automatic logic [9:0] obs_a();
        return {gate_a, busy_a, switched_a};
    endfunction

    function automatic logic [5:0] obs_b();
        return {gate_b, busy_b, switched_b};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Invariant monitor: at most one decoded gate bit is set, and each change
    // between different set bits is separated by enough all-off cycles.
    logic [7:0] last_a = '0;
    int         zrun_a = 0;
    logic [3:0] last_b = '0;
    int         zrun_b = 0;
    always @(negedge clk) begin
        checks++;
        if ($countones(gate_a) > 1) begin
            errors++;
            $display("FAIL popcount_a gate=%h expected at most one bit", gate_a);
        end
        if (gate_a != 8'h00) begin
            if (last_a != 8'h00 && gate_a != last_a) begin
                checks++;
                if (zrun_a < 4) begin
                    errors++;
                    $display("FAIL deadtime_a off_cycles=%0d expected >= 4", zrun_a);
                end
            end
            last_a = gate_a;
            zrun_a = 0;
        end else begin
            zrun_a++;
        end
        checks++;
        if ($countones(~gate_b) > 1) begin
            errors++;
            $display("FAIL popcount_b gate=%h expected at most one low bit", gate_b);
        end
        if (~gate_b != 4'h0) begin
            if (last_b != 4'h0 && ~gate_b != last_b) begin
                checks++;
                if (zrun_b < 1) begin
                    errors++;
                    $display("FAIL deadtime_b off_cycles=%0d expected >= 1", zrun_b);
                end
            end
            last_b = ~gate_b;
            zrun_b = 0;
        end else begin
            zrun_b++;
        end
    end

    task automatic test_reset_enable();
        logic [9:0] exp;
        #3;
        checks++;
        if (obs_a() !== {8'h00, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_state got=%h expected=%h", obs_a(), {8'h00, 2'b00});
        end
        step();
        rst_n_a = 1'b1;
        en_a = 1'b1;
        for (int i = 0; i < 6; i++) begin
            sel_valid_a = (i == 0);
            sel_a = 3'd5;
            step();
            exp = (i < 4) ? {8'h00, 2'b10} : (i == 4) ? {8'h20, 2'b01} : {8'h20, 2'b00};
            checks++;
            if (obs_a() !== exp) begin
                errors++;
                $display("FAIL enable_from_off edge=%0d got=%h expected=%h", i, obs_a(), exp);
            end
        end
    endtask

    // Active is 5. Request 2, then 7 two cycles later; the timer is not restarted.
    task automatic test_retarget_dead();
        logic [9:0] exp;
        for (int i = 0; i < 6; i++) begin
            sel_valid_a = (i == 0) || (i == 2);
            sel_a = (i == 0) ? 3'd2 : 3'd7;
            step();
            exp = (i < 4) ? {8'h00, 2'b10} : (i == 4) ? {8'h80, 2'b01} : {8'h80, 2'b00};
            checks++;
            if (obs_a() !== exp) begin
                errors++;
                $display("FAIL retarget_dead edge=%0d got=%h expected=%h", i, obs_a(), exp);
            end
        end
    endtask

    // Active is 7. Request 2: four all-off cycles, then 8'h04.
    task automatic test_switch_on();
        logic [9:0] exp;
        for (int i = 0; i < 6; i++) begin
            sel_valid_a = (i == 0);
            sel_a = 3'd2;
            step();
            exp = (i < 4) ? {8'h00, 2'b10} : (i == 4) ? {8'h04, 2'b01} : {8'h04, 2'b00};
            checks++;
            if (obs_a() !== exp) begin
                errors++;
                $display("FAIL switch_on edge=%0d got=%h expected=%h", i, obs_a(), exp);
            end
        end
    endtask

    task automatic test_same_and_disable();
        logic [9:0] exp;
        // Phase per step: 0-2 same index, 3 disable, 4-5 enter DEAD,
        // 6 en=0 with sel_valid, 7-9 stay disabled, 10-15 enabled without a request.
        for (int i = 0; i < 16; i++) begin
            en_a        = !(i == 3 || (i >= 6 && i <= 9));
            sel_valid_a = (i <= 2) || (i == 4) || (i == 6);
            sel_a       = (i <= 2) ? 3'd2 : (i == 4) ? 3'd3 : 3'd6;
            step();
            exp = (i <= 2) ? {8'h04, 2'b00} :
                  (i == 4 || i == 5) ? {8'h00, 2'b10} : {8'h00, 2'b00};
            checks++;
            if (obs_a() !== exp) begin
                errors++;
                $display("FAIL same_and_disable step=%0d got=%h expected=%h", i, obs_a(), exp);
            end
        end
    endtask

    task automatic test_async_reset();
        logic [9:0] exp;
        en_a = 1'b1;
        // Mid-DEAD reset
        for (int i = 0; i < 2; i++) begin
            sel_valid_a = (i == 0);
            sel_a = 3'd4;
            step();
        end
        #2;
        rst_n_a = 1'b0;
        #1;
        checks++;
        if (obs_a() !== {8'h00, 2'b00}) begin
            errors++;
            $display("FAIL async_reset_dead got=%h expected=%h", obs_a(), {8'h00, 2'b00});
        end
        step();
        rst_n_a = 1'b1;
        sel_valid_a = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step();
            checks++;
            if (obs_a() !== {8'h00, 2'b00}) begin
                errors++;
                $display("FAIL after_reset_idle step=%0d got=%h expected=%h", i, obs_a(), {8'h00, 2'b00});
            end
        end
        // Mid-ON reset
        for (int i = 0; i < 5; i++) begin
            sel_valid_a = (i == 0);
            sel_a = 3'd4;
            step();
            exp = (i < 4) ? {8'h00, 2'b10} : {8'h10, 2'b01};
            checks++;
            if (obs_a() !== exp) begin
                errors++;
                $display("FAIL reenable edge=%0d got=%h expected=%h", i, obs_a(), exp);
            end
        end
        #2;
        rst_n_a = 1'b0;
        #1;
        checks++;
        if (obs_a() !== {8'h00, 2'b00}) begin
            errors++;
            $display("FAIL async_reset_on got=%h expected=%h", obs_a(), {8'h00, 2'b00});
        end
        step();
        rst_n_a = 1'b1;
    endtask

    task automatic test_active_low_min_dead();
        logic [5:0] exp;
        checks++;
        if (obs_b() !== {4'hF, 2'b00}) begin
            errors++;
            $display("FAIL active_low_reset got=%h expected=%h", obs_b(), {4'hF, 2'b00});
        end
        rst_n_b = 1'b1;
        en_b = 1'b1;
        for (int i = 0; i < 5; i++) begin
            sel_valid_b = (i == 0) || (i == 2);
            sel_b = (i == 0) ? 2'd1 : 2'd3;
            step();
            case (i)
                0:       exp = {4'hF, 2'b10};
                1:       exp = {4'hD, 2'b01};
                2:       exp = {4'hF, 2'b10};
                3:       exp = {4'h7, 2'b01};
                default: exp = {4'h7, 2'b00};
            endcase
            checks++;
            if (obs_b() !== exp) begin
                errors++;
                $display("FAIL active_low edge=%0d got=%h expected=%h", i, obs_b(), exp);
            end
        end
    endtask

    initial begin
        rst_n_a = 1'b0; en_a = 1'b0; sel_valid_a = 1'b0; sel_a = '0;
        rst_n_b = 1'b0; en_b = 1'b0; sel_valid_b = 1'b0; sel_b = '0;
        test_reset_enable();
        test_retarget_dead();
        test_switch_on();
        test_same_and_disable();
        test_async_reset();
        test_active_low_min_dead();
        step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
